// File: rtl/branch_pc_sel_predictor_pkg.sv
// Shared 5-stage selection encodings, branch funct3 codes and counter helpers
// for the fetch-time branch predictor.
package branch_pc_sel_predictor_pkg;

   localparam logic [1:0] PC_SEL_NEXT           = 2'd0;
   localparam logic [1:0] PC_SEL_JUMP_OR_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_PREDICT        = 2'd2;
   localparam logic [1:0] PC_SEL_RECOVER        = 2'd3;

   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_BNE  = 3'b001;
   localparam logic [2:0] FUNCT3_BLT  = 3'b100;
   localparam logic [2:0] FUNCT3_BGE  = 3'b101;
   localparam logic [2:0] FUNCT3_BLTU = 3'b110;
   localparam logic [2:0] FUNCT3_BGEU = 3'b111;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   // Saturating 2-bit counter step.
   function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken && ctr != CTR_STRONG_T) begin
         res = ctr + 2'd1;
      end else if (!taken && ctr != CTR_STRONG_NT) begin
         res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_pc_sel_predictor_cond_eval.sv
// Combinational branch condition: funct3 plus ALU compare flags to taken.
// funct3Valid is low for the two non-branch encodings, which never train.
module branch_cond_eval
   import branch_pc_sel_predictor_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       isEqual,
   input  logic       isLessThan,
   input  logic       isLessThanU,
   output logic       taken,
   output logic       funct3Valid
);

   always_comb begin
      taken       = 1'b0;
      funct3Valid = 1'b1;
      case (funct3)
         FUNCT3_BEQ:  taken = isEqual;
         FUNCT3_BNE:  taken = !isEqual;
         FUNCT3_BLT:  taken = isLessThan;
         FUNCT3_BGE:  taken = !isLessThan;
         FUNCT3_BLTU: taken = isLessThanU;
         FUNCT3_BGEU: taken = !isLessThanU;
         default:     funct3Valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_sel_predictor.sv
// Direct-mapped 2-bit-counter branch predictor and PC-select arbiter; lookup and
// redirect are zero-latency, training lands on the next edge. Stats via PC_SEL_STATS_EN.
module branch_pc_sel_predictor
   import branch_pc_sel_predictor_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = XLEN - IDX_W - 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] ifPc,
   output logic            predictTaken,
   output logic [XLEN-1:0] predictTarget,
   input  logic            exValid,
   input  logic            stall,
   input  logic            exIsBranch,
   input  logic            exIsJump,
   input  logic [2:0]      exFunct3,
   input  logic            exIsEqual,
   input  logic            exIsLessThan,
   input  logic            exIsLessThanU,
   input  logic [XLEN-1:0] exPc,
   input  logic [XLEN-1:0] exTarget,
   input  logic            exPredTaken,
   input  logic [1:0]      oldPcSel,
   output logic [1:0]      newPcSel,
   output logic            flush,
   output logic [31:0]     branchCount,
   output logic [31:0]     mispredictCount
);

   logic             tblValid  [ENTRIES];
   logic [TAG_W-1:0] tblTag    [ENTRIES];
   logic [XLEN-1:0]  tblTarget [ENTRIES];
   logic [1:0]       tblCtr    [ENTRIES];

   logic [IDX_W-1:0] ifIdx, exIdx;
   logic [TAG_W-1:0] ifTag, exTag;
   logic             ifHit, exHit;
   logic             taken, funct3Valid;
   logic             resolve, mispredict, train, exJump;
   logic             unusedPcLsbs;

   assign ifIdx = ifPc[IDX_W+1:2];
   assign ifTag = ifPc[XLEN-1:IDX_W+2];
   assign exIdx = exPc[IDX_W+1:2];
   assign exTag = exPc[XLEN-1:IDX_W+2];
   assign unusedPcLsbs = ^{ifPc[1:0], exPc[1:0]};

   // Lookup reads registered state only, so a same-index write this cycle is not visible.
   assign ifHit         = tblValid[ifIdx] && (tblTag[ifIdx] == ifTag);
   assign exHit         = tblValid[exIdx] && (tblTag[exIdx] == exTag);
   assign predictTaken  = ifHit && tblCtr[ifIdx][1];
   assign predictTarget = ifHit ? tblTarget[ifIdx] : '0;

   branch_cond_eval uCondEval (
      .funct3      (exFunct3),
      .isEqual     (exIsEqual),
      .isLessThan  (exIsLessThan),
      .isLessThanU (exIsLessThanU),
      .taken       (taken),
      .funct3Valid (funct3Valid)
   );

   assign resolve    = exValid && !stall && exIsBranch;
   assign mispredict = resolve && (taken != exPredTaken);
   assign train      = resolve && funct3Valid;
   assign exJump     = exValid && !stall && exIsJump;

   always_comb begin
      newPcSel = oldPcSel;
      flush    = 1'b0;
      if (mispredict && taken) begin
         newPcSel = PC_SEL_JUMP_OR_BRANCH;
         flush    = 1'b1;
      end else if (mispredict) begin
         newPcSel = PC_SEL_RECOVER;
         flush    = 1'b1;
      end else if (exJump) begin
         newPcSel = PC_SEL_JUMP_OR_BRANCH;
         flush    = 1'b1;
      end else if (predictTaken) begin
         newPcSel = PC_SEL_PREDICT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tblValid[i]  <= 1'b0;
            tblTag[i]    <= '0;
            tblTarget[i] <= '0;
            tblCtr[i]    <= CTR_WEAK_NT;
         end
      end else if (train) begin
         tblValid[exIdx]  <= 1'b1;
         tblTag[exIdx]    <= exTag;
         tblTarget[exIdx] <= exTarget;
         // A tag miss means another branch owned the slot; start from a weak state.
         if (exHit) begin
            tblCtr[exIdx] <= ctrStep(tblCtr[exIdx], taken);
         end else begin
            tblCtr[exIdx] <= taken ? CTR_WEAK_T : CTR_WEAK_NT;
         end
      end
   end

`ifdef PC_SEL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (resolve) begin
            branchCount <= branchCount + 32'd1;
         end
         if (mispredict) begin
            mispredictCount <= mispredictCount + 32'd1;
         end
      end
   end
`else
   assign branchCount     = '0;
   assign mispredictCount = '0;
`endif

endmodule

// File: doc/branch_pc_sel_predictor.md
Name: branch_pc_sel_predictor

Overview:
Parametrised successor to the single-cycle PC-select updater in the 5-stage RISC-V core. It adds a direct-mapped branch target table of 2-bit saturating counters, indexed from the IF PC. The table predicts taken branches at fetch and is trained by branches resolved in EX. Each cycle it produces the final pcSel for the PC mux plus a flush for IF/ID when EX detects a misprediction.

Parameters:
XLEN, 32, PC and target width
ENTRIES, 16, table entries; power of two, at least 2
IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2]
TAG_W, XLEN-IDX_W-2, tag = pc[XLEN-1:IDX_W+2]

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ifPc  in  XLEN  fetch-stage PC
predictTaken  out  1  IF hit with counter MSB=1
predictTarget  out  XLEN  stored target on hit, else 0
exValid  in  1  EX holds a real instruction
stall  in  1  pipeline stall; blocks training and redirect
exIsBranch  in  1  EX instruction is a conditional branch
exIsJump  in  1  EX instruction is jal/jalr
exFunct3  in  3  branch funct3
exIsEqual  in  1  ALU rs1==rs2
exIsLessThan  in  1  signed rs1<rs2
exIsLessThanU  in  1  unsigned rs1<rs2
exPc  in  XLEN  PC of EX instruction
exTarget  in  XLEN  computed branch/jump target
exPredTaken  in  1  predictTaken carried down the pipeline with this instruction
oldPcSel  in  2  default select from control unit
newPcSel  out  2  final PC mux select
flush  out  1  squash IF/ID this cycle
branchCount  out  32  resolved conditional branches (stats)
mispredictCount  out  32  mispredictions (stats)

Behaviour:
- The table holds per entry: valid, tag, target, 2-bit counter. Reset clears all entries to valid=0, counter=01 (weakly not-taken), target=0.
- Lookup is combinational from registered state. hit = valid && tag match.
- Taken decode by funct3:
  - 000 beq: eq
  - 001 bne: !eq
  - 100 blt: lt
  - 101 bge: !lt
  - 110 bltu: ltu
  - 111 bgeu: !ltu
  - 010 and 011: not taken, no training.
- resolve = exValid && !stall && exIsBranch.
- mispredict = resolve && (taken != exPredTaken).
- Training on the clk edge when resolve is high, at the exPc index:
  - Write tag and target, set valid.
  - If the tag was a miss, seed the counter to 10 when taken or 01 when not taken.
  - If the tag was a hit, increment the counter (saturate at 11) when taken, decrement it (saturate at 00) when not taken.
- IF and EX accessing the same index in the same cycle: IF sees the pre-update value (read before write).
- newPcSel priority, combinational, zero latency:
  1. mispredict && taken: PC_SEL_JUMP_OR_BRANCH
  2. mispredict && !taken: PC_SEL_RECOVER (mux selects exPc+4)
  3. exValid && !stall && exIsJump: PC_SEL_JUMP_OR_BRANCH (table untouched)
  4. predictTaken: PC_SEL_PREDICT
  5. otherwise: oldPcSel
- flush = 1 exactly when case 1, 2 or 3 applies.
- With stall=1: no training, no flush, and newPcSel follows only cases 4 and 5.
- Reset asserted mid-operation clears the table immediately. predictTaken then reads 0 and newPcSel reduces to oldPcSel unless EX redirects.

Optional Feature:
PC_SEL_STATS_EN
- Defined: two 32-bit wrapping counters, reset to 0.
  - branchCount increments on resolve.
  - mispredictCount increments on mispredict.
  - Both update on the same edge as training.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- The shared 5-stage selections header gains the 2-bit encodings:
  - PC_SEL_NEXT = 0
  - PC_SEL_JUMP_OR_BRANCH = 1
  - PC_SEL_PREDICT = 2
  - PC_SEL_RECOVER = 3
- The same header also holds the branch funct3 constants.
- Sub-module branch_cond_eval: combinational funct3 plus flags to taken. It replaces the shared equality-only branch checker.

Test Plan:
- Reset with rst_n=0 then 1, ifPc=0x100: predictTaken=0, predictTarget=0, newPcSel=oldPcSel=0, counts 0.
- Taken beq at exPc=0x100, exTarget=0x180, eq=1, exPredTaken=0: newPcSel=1, flush=1. Next cycle ifPc=0x100 gives predictTaken=1, target 0x180, newPcSel=2.
- Same branch resolved not-taken three times with exPredTaken=1: first gives newPcSel=3 and flush. Counter walks 10, 01, 00, saturating at 00; predictTaken=0 after the first.
- Aliasing: train 0x100 taken, then look up 0x140 (same index, ENTRIES=16): tag miss gives predictTaken=0.
- stall=1 with a mispredicting branch in EX: flush=0, table and counts unchanged. Deassert stall: redirect and training occur that cycle.
- With PC_SEL_STATS_EN: 5 branches including 2 mispredicts gives branchCount=5, mispredictCount=2. Without the macro both read 0.
